switch_debounce: RTL

Conditions a raw mechanical switch or push-button into clean, glitch-free signals for the CPU datapath. The raw input is brought into the `clk` domain through a two-flop synchronizer. A counter-based state machine accepts a level change only after it has been stable for `STABLE_COUNT` consecutive samples. It produces a debounced level plus single-cycle press and release strobes, which feed the storage stages (d_ff, registers) as their clock-enable / step source.

---
 rtl/switch_debounce.sv | 112 +++++++++++
 1 files changed

// File: rtl/switch_debounce.sv
// Debouncer for a raw switch/button: two-flop synchronizer followed by a
// counter-qualified FSM producing a clean level plus press/release strobes.
module switch_debounce #(
    parameter int STABLE_COUNT = 1_000_000,
    parameter int CNT_W        = $clog2(STABLE_COUNT)
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_in,
    output logic db_level,
    output logic db_press,
    output logic db_release,
    output logic db_busy
);

    typedef enum logic [1:0] {
        IDLE_LOW  = 2'd0,
        WAIT_HIGH = 2'd1,
        IDLE_HIGH = 2'd2,
        WAIT_LOW  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic             btn_s1;
    logic             btn_sync;
    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             level_nxt;
    logic             press_nxt;
    logic             release_nxt;

    always_ff @(posedge clk) begin
        if (reset) begin
            btn_s1   <= 1'b0;
            btn_sync <= 1'b0;
        end else begin
            btn_s1   <= btn_in;
            btn_sync <= btn_s1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE_LOW;
            cnt        <= '0;
            db_level   <= 1'b0;
            db_press   <= 1'b0;
            db_release <= 1'b0;
            db_busy    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            db_level   <= level_nxt;
            db_press   <= press_nxt;
            db_release <= release_nxt;
            db_busy    <= (state_nxt == WAIT_HIGH) || (state_nxt == WAIT_LOW);
        end
    end

    // cnt holds the number of agreeing samples already seen in a WAIT state
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = '0;
        level_nxt   = db_level;
        press_nxt   = 1'b0;
        release_nxt = 1'b0;
        unique case (state)
            IDLE_LOW: begin
                if (btn_sync) begin
                    state_nxt = WAIT_HIGH;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_HIGH: begin
                if (!btn_sync) begin
                    state_nxt = IDLE_LOW;
                end else if (cnt == CNT_LAST) begin
                    state_nxt = IDLE_HIGH;
                    level_nxt = 1'b1;
                    press_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            IDLE_HIGH: begin
                if (!btn_sync) begin
                    state_nxt = WAIT_LOW;
                    cnt_nxt   = CNT_W'(1);
                end
            end
            WAIT_LOW: begin
                if (btn_sync) begin
                    state_nxt = IDLE_HIGH;
                end else if (cnt == CNT_LAST) begin
                    state_nxt   = IDLE_LOW;
                    level_nxt   = 1'b0;
                    release_nxt = 1'b1;
                end else begin
                    cnt_nxt = cnt + CNT_W'(1);
                end
            end
            default: begin
                state_nxt = IDLE_LOW;
                level_nxt = 1'b0;
            end
        endcase
    end

endmodule
